// File: rtl/lsu_pkg.sv
// Shared types and request-decode helpers for the load/store memory master.
package lsu_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'd0,
      F3_H  = 3'd1,
      F3_W  = 3'd2,
      F3_BU = 3'd4,
      F3_HU = 3'd5
   } funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_OOB        = 2'd2,
      ERR_ILLEGAL    = 2'd3
   } rsp_err_e;

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return f3 > 3'd2;
      end
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   // Only the access size (funct3[1:0]) matters for alignment.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'd1:    return lo[0];
         2'd2:    return lo != 2'd0;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction with sign/zero extension and store lane merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [15:0] half_sel;

   assign shamt    = {lane_i, 3'b000};
   assign shifted  = word_i >> shamt;
   assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      load_data_o = word_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data_o = {24'd0, shifted[7:0]};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'd0, half_sel};
         default: load_data_o = word_i;
      endcase
   end

   // Sub-word stores keep every byte of the fetched word outside the target lane(s).
   always_comb begin
      merge_data_o = wdata_i;
      case (funct3_i)
         F3_B:    merge_data_o = (word_i & ~(32'h0000_00FF << shamt)) |
                                 ({24'd0, wdata_i[7:0]} << shamt);
         F3_H:    merge_data_o = lane_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                           : {word_i[31:16], wdata_i[15:0]};
         default: merge_data_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: validates one request per handshake and turns it into word-aligned memory accesses.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
   parameter int                MEM_BYTES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DWIDTH-1:0] rsp_rdata_o,
   output logic [1:0]        rsp_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   localparam logic [AWIDTH-1:0] LIMIT_ADDR = BASE_ADDR + AWIDTH'(MEM_BYTES);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   rsp_err_e          rsp_err_q, rsp_err_d;
   logic [DWIDTH-1:0] mem_data_q, mem_data_d;
   logic              read_en_q, read_en_d;
   logic              write_en_q, write_en_d;

   logic              accept;
   logic [AWIDTH-1:0] req_word_addr;
   rsp_err_e          req_err;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;

   lsu_align u_align (
      .funct3_i     (funct3_q),
      .lane_i       (addr_q[1:0]),
      .word_i       (mem_data_i),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .merge_data_o (merge_data)
   );

   assign accept        = req_valid_i && req_ready_o;
   assign req_word_addr = {req_addr_i[AWIDTH-1:2], 2'b00};

   always_comb begin
      req_err = ERR_NONE;
      if (f3_illegal(req_we_i, req_funct3_i)) begin
         req_err = ERR_ILLEGAL;
      end else if (f3_misaligned(req_funct3_i, req_addr_i[1:0])) begin
         req_err = ERR_MISALIGNED;
      end else if ((req_word_addr < BASE_ADDR) ||
                   ((req_word_addr + AWIDTH'(3)) >= LIMIT_ADDR)) begin
         req_err = ERR_OOB;
      end
   end

   // Enables and response fields default low so they are only ever high in their own state.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_data_d  = mem_data_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = ERR_NONE;
      read_en_d   = 1'b0;
      write_en_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d     = req_we_i;
               funct3_d = req_funct3_i;
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               if (req_err != ERR_NONE) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = req_err;
               end else if (req_we_i && (req_funct3_i == F3_W)) begin
                  state_d    = ST_WRITE;
                  write_en_d = 1'b1;
                  mem_data_d = req_wdata_i;
               end else begin
                  state_d   = ST_READ;
                  read_en_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (we_q) begin
               state_d    = ST_WRITE;
               write_en_d = 1'b1;
               mem_data_d = merge_data;
            end else begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data;
            end
         end
         ST_WRITE: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_NONE;
         mem_data_q  <= '0;
         read_en_q   <= 1'b0;
         write_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_data_q  <= mem_data_d;
         read_en_q   <= read_en_d;
         write_en_q  <= write_en_d;
      end
   end

   // Gating with rst lets a reset arriving mid-write suppress the commit in that same cycle.
   assign req_ready_o    = (state_q == ST_IDLE) && rst;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign rsp_err_o      = rsp_err_q;
   assign mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
   assign mem_data_o     = mem_data_q;
   assign mem_read_en_o  = read_en_q && rst;
   assign mem_write_en_o = write_en_q && rst;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a byte-array reference model.
module tb_lsu_mem_master;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam int          MEMB = 4096;

   logic        clk;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_read_en_o;
   logic        mem_write_en_o;
   logic [31:0] mem_data_i;

   int num_checks = 0;
   int num_fail   = 0;
   int read_cnt   = 0;
   int write_cnt  = 0;
   int overlap_cnt = 0;

   logic [31:0] tb_mem  [0:MEMB/4-1];
   logic [7:0]  ref_mem [0:MEMB-1];

   logic [31:0] last_rdata;
   logic [1:0]  last_err;
   int          last_lat;

   lsu_mem_master dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_funct3_i   (req_funct3_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_read_en_o  (mem_read_en_o),
      .mem_write_en_o (mem_write_en_o),
      .mem_data_i     (mem_data_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bench-side memory: combinational read, write committed at posedge.
   always_comb begin
      mem_data_i = 32'h0;
      if (mem_addr_o >= BASE && mem_addr_o < BASE + MEMB)
         mem_data_i = tb_mem[(mem_addr_o - BASE) >> 2];
   end

   always @(posedge clk) begin
      if (mem_write_en_o && mem_addr_o >= BASE && mem_addr_o < BASE + MEMB)
         tb_mem[(mem_addr_o - BASE) >> 2] <= mem_data_o;
   end

   // Enable activity monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (mem_read_en_o)  read_cnt  = read_cnt + 1;
      if (mem_write_en_o) write_cnt = write_cnt + 1;
      if ((mem_read_en_o && mem_write_en_o) || (rsp_valid_o && (mem_read_en_o || mem_write_en_o)))
         overlap_cnt = overlap_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      longint a, w;
      bit legal;
      a = longint'(addr);
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'd3;
      if (a % acc_size(f3) != 0) return 2'd1;
      w = a - (a % 4);
      if (w < longint'(BASE) || w + 4 > longint'(BASE) + MEMB) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      int off, sz;
      logic [31:0] v;
      off = int'(addr - BASE);
      sz  = acc_size(f3);
      v   = 32'd0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
      if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   function automatic logic [31:0] model_word(input int widx);
      return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
   endfunction

   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata);
      int waited, r0, w0, e_lat, e_rd, e_wr, sz, off;
      logic [1:0]  e_err;
      logic [31:0] e_rdata;
      waited = 0;
      while (!req_ready_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready_o) begin
         checkOutput("ready_timeout", 32'(req_ready_o), 32'd1);
         return;
      end
      e_err   = model_err(we, f3, addr);
      e_rdata = (e_err == 2'd0 && !we) ? model_load(f3, addr) : 32'd0;
      if (e_err != 2'd0)           begin e_lat = 1; e_rd = 0; e_wr = 0; end
      else if (!we)                begin e_lat = 2; e_rd = 1; e_wr = 0; end
      else if (acc_size(f3) == 4)  begin e_lat = 2; e_rd = 0; e_wr = 1; end
      else                         begin e_lat = 3; e_rd = 1; e_wr = 1; end
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      r0 = read_cnt;
      w0 = write_cnt;
      @(posedge clk);
      last_lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) req_valid_i = 1'b0;
         if (rsp_valid_o) begin
            last_lat = n;
            break;
         end
      end
      last_rdata = rsp_rdata_o;
      last_err   = rsp_err_o;
      checkOutput("rsp_latency", 32'(last_lat), 32'(e_lat));
      checkOutput("rsp_err", 32'(last_err), 32'(e_err));
      checkOutput("rsp_rdata", last_rdata, e_rdata);
      checkOutput("read_cycles", 32'(read_cnt - r0), 32'(e_rd));
      checkOutput("write_cycles", 32'(write_cnt - w0), 32'(e_wr));
      if (we && e_err == 2'd0) begin
         sz  = acc_size(f3);
         off = int'(addr - BASE);
         for (int i = 0; i < sz; i++) ref_mem[off + i] = wdata[8*i +: 8];
      end
      if (we && addr >= BASE && addr < BASE + MEMB)
         checkOutput("mem_word", tb_mem[(addr - BASE) >> 2], model_word(int'((addr - BASE) >> 2)));
      @(negedge clk);
      checkOutput("rsp_pulse", 32'(rsp_valid_o), 32'd0);
      checkOutput("ready_after", 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      logic [31:0] a, w;
      logic [2:0]  f3;
      logic        we;
      int          sel;
      for (int i = 0; i < MEMB / 4; i++) begin
         w = $urandom;
         if (i == 1) w = 32'h8899_AABB;
         tb_mem[i] = w;
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
      end
      rst = 1'b0;
      req_valid_i = 1'b0;
      req_we_i = 1'b0;
      req_funct3_i = 3'd0;
      req_addr_i = 32'd0;
      req_wdata_i = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready", 32'(req_ready_o), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset_enables", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
      checkOutput("reset_err", 32'(rsp_err_o), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(req_ready_o), 32'd1);

      $display("[TB] lane extraction loads");
      applyStimulus(1'b0, 3'd0, 32'h0100_0005, 32'd0);
      checkOutput("lb_value", last_rdata, 32'hFFFF_FFAA);
      applyStimulus(1'b0, 3'd4, 32'h0100_0005, 32'd0);
      checkOutput("lbu_value", last_rdata, 32'h0000_00AA);
      applyStimulus(1'b0, 3'd5, 32'h0100_0006, 32'd0);
      checkOutput("lhu_value", last_rdata, 32'h0000_8899);

      $display("[TB] reset during write");
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd1;
      req_addr_i = 32'h0100_0004; req_wdata_i = 32'h0000_BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("write_before_rst", 32'(mem_write_en_o), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("write_gated_by_rst", 32'(mem_write_en_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sel = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid_o) sel++;
      end
      checkOutput("no_rsp_after_rst", 32'(sel), 32'd0);
      checkOutput("word_unchanged", tb_mem[1], 32'h8899_AABB);
      checkOutput("idle_after_rst", 32'(req_ready_o), 32'd1);

      $display("[TB] error cases");
      applyStimulus(1'b0, 3'd1, 32'h0100_0003, 32'd0);
      checkOutput("lh_misaligned", 32'(last_err), 32'd1);
      applyStimulus(1'b0, 3'd3, 32'h0100_0004, 32'd0);
      checkOutput("load_f3_illegal", 32'(last_err), 32'd3);

      $display("[TB] sub-word store");
      applyStimulus(1'b1, 3'd0, 32'h0100_0006, 32'h0000_0012);
      checkOutput("sb_word", tb_mem[1], 32'h8812_AABB);
      applyStimulus(1'b0, 3'd2, 32'h0100_0004, 32'd0);
      checkOutput("lw_after_sb", last_rdata, 32'h8812_AABB);

      $display("[TB] window boundaries");
      applyStimulus(1'b1, 3'd2, 32'h00FF_FFFC, 32'h1111_2222);
      checkOutput("sw_below_oob", 32'(last_err), 32'd2);
      applyStimulus(1'b1, 3'd2, 32'h0100_1000, 32'h3333_4444);
      checkOutput("sw_above_oob", 32'(last_err), 32'd2);
      applyStimulus(1'b1, 3'd2, 32'h0100_0FFC, 32'hCAFE_F00D);
      checkOutput("sw_top_ok", 32'(last_err), 32'd0);
      checkOutput("sw_top_word", tb_mem[MEMB/4-1], 32'hCAFE_F00D);

      $display("[TB] back-to-back with valid held");
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd2;
      req_addr_i = 32'h0100_0008;
      @(posedge clk);
      @(negedge clk);
      req_addr_i = 32'h0100_000C;
      checkOutput("busy_ready_0", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_rsp1_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("b2b_rsp1_rdata", rsp_rdata_o, model_word(2));
      checkOutput("busy_ready_1", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_ready_idle", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      checkOutput("b2b_accepted", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_rsp2_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("b2b_rsp2_rdata", rsp_rdata_o, model_word(3));
      @(negedge clk);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 300; t++) begin
         we  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         case (sel)
            0:       a = BASE - 32'($urandom_range(1, 8));
            1:       a = BASE + MEMB - 32'($urandom_range(1, 8));
            2:       a = BASE + MEMB + 32'($urandom_range(0, 7));
            3:       a = $urandom;
            default: a = BASE + 32'($urandom_range(0, 63));
         endcase
         if (sel > 5) a = a & ~32'(acc_size(f3) - 1);
         applyStimulus(we, f3, a, $urandom);
      end

      checkOutput("enable_overlap", 32'(overlap_cnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
